sram_port_arbiter: RTL and testbench

Two-to-one arbiter that shares a single sram-like memory port between the instruction-fetch requester and the data (load/store) requester of the CPU. It sits between the fetch/memory stages and the downstream sram-to-AXI bridge. It grants one request per cycle, tracks up to `OUTSTANDING` in-flight transactions in issue order, and routes each returning `mem_data_ok`/`mem_rdata` to the requester that issued it.

---
 rtl/cpu_mem_pkg.sv | 15 +
 rtl/arb_owner_fifo.sv | 53 +++++
 rtl/sram_port_arbiter.sv | 124 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared CPU memory-side definitions: requester owner IDs, access sizes and reset PC.
package cpu_mem_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [1:0]  SZ_BYTE  = 2'd0;
    localparam logic [1:0]  SZ_HALF  = 2'd1;
    localparam logic [1:0]  SZ_WORD  = 2'd2;

    localparam logic [31:0] RESET_PC = 32'hbfc00000;

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order FIFO of 1-bit owner IDs for transactions accepted but not yet answered.
module arb_owner_fifo #(
    parameter int unsigned Depth = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic                   push_data,
    input  logic                   pop,
    output logic                   head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] count
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [Depth-1:0] slot_q;
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CntW'(Depth));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = slot_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                slot_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one sram-like port between fetch and data requesters, routing responses in issue order.
// Define ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed data-over-inst priority.
module sram_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    logic                         grant_inst, grant_data;
    logic                         fifo_push, fifo_full, fifo_empty, fifo_head;
    logic [$clog2(OUTSTANDING):0] fifo_count;
    logic                         resp_valid, stray_resp;
    logic                         err_q;
    owner_e                       push_owner;

`ifdef ARB_ROUND_ROBIN_EN
    // Points at the requester that wins the next contested cycle.
    owner_e rr_prio_q, rr_prio_d;

    always_comb begin
        rr_prio_d = rr_prio_q;
        if (inst_addr_ok) begin
            rr_prio_d = OWN_DATA;
        end else if (data_addr_ok) begin
            rr_prio_d = OWN_INST;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_prio_q <= OWN_DATA;
        end else begin
            rr_prio_q <= rr_prio_d;
        end
    end
`endif

    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (!fifo_full) begin
            if (inst_req && data_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                grant_inst = (rr_prio_q == OWN_INST);
                grant_data = (rr_prio_q == OWN_DATA);
`else
                grant_data = 1'b1;
`endif
            end else begin
                grant_inst = inst_req;
                grant_data = data_req;
            end
        end
    end

    assign mem_req   = (inst_req | data_req) & ~fifo_full;
    assign mem_wr    = grant_inst ? 1'b0 : data_wr;
    assign mem_size  = grant_inst ? SZ_WORD : data_size;
    assign mem_addr  = grant_inst ? inst_addr : data_addr;
    assign mem_wdata = data_wdata;

    assign inst_addr_ok = grant_inst & mem_addr_ok;
    assign data_addr_ok = grant_data & mem_addr_ok;
    assign fifo_push    = inst_addr_ok | data_addr_ok;
    assign push_owner   = data_addr_ok ? OWN_DATA : OWN_INST;

    arb_owner_fifo #(
        .Depth (OUTSTANDING)
    ) u_owner_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data (push_owner),
        .pop       (resp_valid),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A response with nothing outstanding is dropped and only flagged.
    assign resp_valid = mem_data_ok & ~fifo_empty;
    assign stray_resp = mem_data_ok & (fifo_count == '0);

    assign inst_data_ok = resp_valid & (owner_e'(fifo_head) == OWN_INST);
    assign data_data_ok = resp_valid & (owner_e'(fifo_head) == OWN_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else if (stray_resp) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized and directed bench for sram_port_arbiter against an owner-queue reference model.
module tb_sram_port_arbiter;
    localparam int unsigned OUT = 2;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    sram_port_arbiter #(
        .OUTSTANDING (OUT)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference model: queue of issued owners (1 = data), contested-grant preference, sticky error.
    bit q[$];
    bit rr_data;
    bit err_m;

    logic        s_iaok, s_daok, s_idok, s_ddok, s_mreq, s_mwr;
    logic [31:0] s_irdata, s_drdata, s_maddr, s_mwdata;
    logic [1:0]  s_msize;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    endtask

    // Asserts reset mid-cycle; occupancy must clear without waiting for a clock edge.
    task automatic do_reset();
        drive_idle();
        resetn = 1'b0;
        q.delete();
        rr_data = 1'b1;
        err_m   = 1'b0;
        #1;
        check("rst_count", 32'(dut.u_owner_fifo.count), 0);
        check("rst_err", 32'(dut.err_q), 0);
        check("rst_iaok", 32'(inst_addr_ok), 0);
        check("rst_daok", 32'(data_addr_ok), 0);
        check("rst_idok", 32'(inst_data_ok), 0);
        check("rst_ddok", 32'(data_data_ok), 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    // One cycle: drive, compare combinational outputs with the model, clock, compare state.
    task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [1:0] ds, input logic [31:0] da, input logic [31:0] dwd,
                        input logic mao, input logic mdo, input logic [31:0] mrd);
        bit full, gi, gd, nonempty, hd, e_idok, e_ddok;
        inst_req = ir; inst_addr = ia;
        data_req = dr; data_wr = dw; data_size = ds; data_addr = da; data_wdata = dwd;
        mem_addr_ok = mao; mem_data_ok = mdo; mem_rdata = mrd;
        #2;
        s_iaok = inst_addr_ok; s_daok = data_addr_ok; s_idok = inst_data_ok;
        s_ddok = data_data_ok; s_mreq = mem_req; s_mwr = mem_wr; s_msize = mem_size;
        s_irdata = inst_rdata; s_drdata = data_rdata; s_maddr = mem_addr; s_mwdata = mem_wdata;

        full = (q.size() >= OUT);
        gi = 1'b0;
        gd = 1'b0;
        if (!full) begin
            if (ir && dr) begin
                if (RR && !rr_data) gi = 1'b1;
                else gd = 1'b1;
            end else begin
                gi = ir;
                gd = dr;
            end
        end
        check("mem_req", 32'(s_mreq), 32'((ir | dr) & !full));
        check("inst_addr_ok", 32'(s_iaok), 32'(gi & mao));
        check("data_addr_ok", 32'(s_daok), 32'(gd & mao));
        if (gi) begin
            check("inst_mem_addr", s_maddr, ia);
            check("inst_mem_wr", 32'(s_mwr), 0);
            check("inst_mem_size", 32'(s_msize), 2);
        end
        if (gd) begin
            check("data_mem_addr", s_maddr, da);
            check("data_mem_wr", 32'(s_mwr), 32'(dw));
            check("data_mem_size", 32'(s_msize), 32'(ds));
            if (dw) check("data_mem_wdata", s_mwdata, dwd);
        end

        nonempty = (q.size() != 0);
        hd = nonempty ? q[0] : 1'b0;
        e_idok = mdo && nonempty && !hd;
        e_ddok = mdo && nonempty && hd;
        check("inst_data_ok", 32'(s_idok), 32'(e_idok));
        check("data_data_ok", 32'(s_ddok), 32'(e_ddok));
        if (e_idok) check("inst_rdata", s_irdata, mrd);
        if (e_ddok) check("data_rdata", s_drdata, mrd);

        if (mdo && !nonempty) err_m = 1'b1;
        if (mdo && nonempty) void'(q.pop_front());
        if (gi && mao) begin q.push_back(1'b0); rr_data = 1'b1; end
        if (gd && mao) begin q.push_back(1'b1); rr_data = 1'b0; end

        @(posedge clk);
        #1;
        check("count", 32'(dut.u_owner_fifo.count), q.size());
        check("err", 32'(dut.err_q), 32'(err_m));
    endtask

    bit          pi, pd, dw_r, mdo_r, mao_r;
    logic [31:0] ia_r, da_r, dwd_r;
    logic [1:0]  ds_r;

    initial begin
        drive_idle();
        resetn = 1'b1;
        #1;
        do_reset();

        // Single fetch, answered two cycles later.
        step(1, 32'hbfc00000, 0, 0, 0, 0, 0, 1, 0, 0);
        check("t1_iaok", 32'(s_iaok), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3c1d0001);
        check("t1_idok", 32'(s_idok), 1);
        check("t1_irdata", s_irdata, 32'h3c1d0001);
        check("t1_ddok", 32'(s_ddok), 0);

        // Contention; the second cycle also pushes and pops together.
        do_reset();
        step(1, 32'h100, 1, 0, 2, 32'h200, 0, 1, 0, 0);
        check("t2_first_daok", 32'(s_daok), 1);
        check("t2_first_iaok", 32'(s_iaok), 0);
`ifdef ARB_ROUND_ROBIN_EN
        step(1, 32'h100, 1, 0, 2, 32'h204, 0, 1, 1, 32'h11);
        check("t2_rr_iaok", 32'(s_iaok), 1);
        check("t2_pushpop_cnt", 32'(dut.u_owner_fifo.count), 1);
        step(1, 32'h104, 1, 0, 2, 32'h204, 0, 1, 1, 32'h22);
        check("t2_rr_daok", 32'(s_daok), 1);
`else
        step(1, 32'h100, 0, 0, 2, 32'h204, 0, 1, 1, 32'h11);
        check("t2_fx_iaok", 32'(s_iaok), 1);
        check("t2_pushpop_cnt", 32'(dut.u_owner_fifo.count), 1);
`endif

        // Mixed owners answered in issue order.
        do_reset();
        step(1, 32'hbfc00004, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 2, 32'h80000000, 32'h12345678, 1, 0, 0);
        check("t4_wdata", s_mwdata, 32'h12345678);
        check("t4_wr", 32'(s_mwr), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'haaaa5555);
        check("t4_idok", 32'(s_idok), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0);
        check("t4_ddok", 32'(s_ddok), 1);

        // Full owner FIFO blocks all grants.
        do_reset();
        step(1, 32'h10, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 32'h20, 0, 1, 0, 0);
        step(1, 32'h14, 1, 0, 0, 32'h24, 0, 1, 0, 0);
        check("t5_mreq", 32'(s_mreq), 0);
        check("t5_iaok", 32'(s_iaok), 0);
        check("t5_daok", 32'(s_daok), 0);
        check("t5_count", 32'(dut.u_owner_fifo.count), 2);
        // Reset with two outstanding, then a late response hits the empty FIFO.
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hdead);
        check("t6_idok", 32'(s_idok), 0);
        check("t6_ddok", 32'(s_ddok), 0);
        check("t6_err", 32'(dut.err_q), 1);

        // Randomized traffic; requesters hold their request until accepted.
        do_reset();
        pi = 0;
        pd = 0;
        for (int c = 0; c < 400; c++) begin
            if (!pi && $urandom_range(0, 2) != 0) begin
                pi = 1;
                ia_r = $urandom() & 32'hffff_fffc;
            end
            if (!pd && $urandom_range(0, 2) != 0) begin
                pd = 1;
                da_r = $urandom();
                dw_r = 1'($urandom_range(0, 1));
                ds_r = 2'($urandom_range(0, 2));
                dwd_r = $urandom();
            end
            mao_r = ($urandom_range(0, 3) != 0);
            mdo_r = ($urandom_range(0, 9) < 4);
            step(pi, ia_r, pd, dw_r, ds_r, da_r, dwd_r, mao_r, mdo_r, $urandom());
            if (s_iaok) pi = 0;
            if (s_daok) pd = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
